// File: rtl/native_mem_responder.sv
// native_mem_responder: memory-side responder for the picorv32 native bus.
// Word RAM with byte-lane writes, programmable read/write wait states,
// sticky out-of-range flag with first-offender address, saturating stats.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_valid, mem_instr  request valid, fetch qualifier (unused)
//   mem_addr, mem_wdata   byte address, write data
//   mem_wstrb             byte-lane enables, 0 = read
//   mem_ready, mem_rdata  one-cycle response pulse, read data
//   oob_err, oob_addr     sticky out-of-range flag, first bad address
//   rd_count, wr_count    completed reads / writes, saturating
module native_mem_responder #(
    parameter int unsigned WORDS      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 0,
    parameter logic [31:0] OOB_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        oob_err,
    output logic [31:0] oob_addr,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] RD_WAIT = 4'(READ_WAIT);
    localparam logic [3:0] WR_WAIT = 4'(WRITE_WAIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        oob_err_q;
    logic [31:0] oob_addr_q;
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    logic [31:0] ram_q [WORDS];

    // In IDLE the request is still on the bus; a zero-wait read must
    // fetch its data from the live address before it is latched.
    logic          accept;
    logic [31:0]   src_addr;
    logic          src_wr;
    logic [31:0]   off;
    logic          src_oob;
    logic [IW-1:0] src_idx;
    logic [31:0]   rd_word;
    logic [3:0]    req_wait;
    logic          ram_we;
    logic          unused;

    assign accept   = (state_q == S_IDLE) && mem_valid;
    assign src_addr = (state_q == S_IDLE) ? mem_addr : addr_q;
    assign src_wr   = (state_q == S_IDLE) ? (|mem_wstrb) : (|wstrb_q);
    assign off      = src_addr - BASE_ADDR;
    assign src_oob  = (src_addr[31:2] < BASE_ADDR[31:2]) ||
                      ({2'b00, off[31:2]} >= WORDS);
    assign src_idx  = off[IW+1:2];
    assign rd_word  = src_oob ? OOB_RDATA : ram_q[src_idx];
    assign req_wait = (|mem_wstrb) ? WR_WAIT : RD_WAIT;
    assign ram_we   = (state_q == S_RESP) && src_wr && !src_oob;
    assign unused   = ^{mem_instr, off[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (req_wait != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = req_wait;
                    end else begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        if (!src_wr) rdata_d = rd_word;
                    end
                end
            end
            S_WAIT: begin
                // Initiator withdrew the request: drop it silently.
                if (!mem_valid) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    if (!src_wr) rdata_d = rd_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            oob_err_q  <= 1'b0;
            oob_addr_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (state_q == S_RESP) begin
                if (src_wr) begin
                    if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
                end else begin
                    if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
                end
                if (src_oob) begin
                    oob_err_q <= 1'b1;
                    // Keep the first offender only.
                    if (!oob_err_q) oob_addr_q <= addr_q;
                end
            end
        end
    end

    // RAM is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k]) ram_q[src_idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign oob_err   = oob_err_q;
    assign oob_addr  = oob_addr_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_native_mem_responder.sv
// tb_native_mem_responder: two responder instances (default and
// offset-base/long-wait) driven by directed and random transactions.
module tb_native_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        valid  [2];
    logic        instr  [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic        ready  [2];
    logic [31:0] rdata  [2];
    logic        oerr   [2];
    logic [31:0] oaddr  [2];
    logic [15:0] rdc    [2];
    logic [15:0] wrc    [2];

    native_mem_responder dut0 (
        .clk(clk), .reset(rst[0]), .mem_valid(valid[0]),
        .mem_instr(instr[0]), .mem_ready(ready[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]),
        .oob_err(oerr[0]), .oob_addr(oaddr[0]), .rd_count(rdc[0]),
        .wr_count(wrc[0])
    );

    native_mem_responder #(
        .WORDS(16), .BASE_ADDR(32'h0000_1000),
        .READ_WAIT(3), .WRITE_WAIT(2)
    ) dut1 (
        .clk(clk), .reset(rst[1]), .mem_valid(valid[1]),
        .mem_instr(instr[1]), .mem_ready(ready[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]),
        .oob_err(oerr[1]), .oob_addr(oaddr[1]), .rd_count(rdc[1]),
        .wr_count(wrc[1])
    );

    // Reference model
    logic [31:0] BASE   [2];
    int          WORDS_M[2];
    int          RW     [2];
    int          WW     [2];
    logic [31:0] mdl    [2][32];
    int          exp_rd [2];
    int          exp_wr [2];
    logic        exp_oerr [2];
    logic [31:0] exp_oaddr[2];
    logic [31:0] exp_rdata[2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oob(input int d, input logic [31:0] a);
        if (a < BASE[d]) return 1'b1;
        return ((a - BASE[d]) >> 2) >= 32'(WORDS_M[d]);
    endfunction

    task automatic clr_model(input int d);
        exp_rd[d]    = 0;
        exp_wr[d]    = 0;
        exp_oerr[d]  = 1'b0;
        exp_oaddr[d] = '0;
        exp_rdata[d] = '0;
    endtask

    task automatic check_stats(input int d, input string tag);
        check({tag, "_rd_count"}, 32'(rdc[d]), exp_rd[d]);
        check({tag, "_wr_count"}, 32'(wrc[d]), exp_wr[d]);
        check({tag, "_oob_err"},  32'(oerr[d]), 32'(exp_oerr[d]));
        check({tag, "_oob_addr"}, oaddr[d], exp_oaddr[d]);
    endtask

    // Caller is 1 time unit after a posedge with the DUT idle.
    task automatic xact(input int d, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        int n;
        int k;
        int idx;
        bit oob;
        n   = (ws != 4'd0) ? WW[d] : RW[d];
        oob = is_oob(d, a);
        idx = int'((a - BASE[d]) >> 2);
        valid[d] = 1'b1;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        instr[d] = 1'($urandom);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            // Bus noise while waiting must not leak into the transaction.
            if (!ready[d]) begin
                addr[d]  = $urandom;
                wdata[d] = $urandom;
                wstrb[d] = 4'($urandom);
            end
        end while (!ready[d] && k < 20);
        check("latency", k, 1 + n);
        if (ws == 4'd0) begin
            exp_rdata[d] = oob ? 32'hDEAD_BEEF : mdl[d][idx];
            exp_rd[d]    = (exp_rd[d] == 65535) ? 65535 : exp_rd[d] + 1;
        end else begin
            if (!oob) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
            exp_wr[d] = (exp_wr[d] == 65535) ? 65535 : exp_wr[d] + 1;
        end
        check("rdata", rdata[d], exp_rdata[d]);
        if (oob) begin
            if (!exp_oerr[d]) exp_oaddr[d] = a;
            exp_oerr[d] = 1'b1;
        end
        valid[d] = 1'b0;
        wstrb[d] = '0;
        @(posedge clk);
        #1;
        check("single_pulse", 32'(ready[d]), 0);
        check_stats(d, "post");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;

        BASE[0] = 32'h0;      BASE[1] = 32'h1000;
        WORDS_M[0] = 32;      WORDS_M[1] = 16;
        RW[0] = 1;            RW[1] = 3;
        WW[0] = 0;            WW[1] = 2;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; instr[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
            clr_model(d);
        end
        step();
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", 32'(ready[d]), 0);
            check("reset_rdata", rdata[d], 0);
            check_stats(d, "reset");
        end

        // Fill every word so all later reads are defined.
        for (int i = 0; i < 32; i++) xact(0, 32'(i * 4), $urandom, 4'hF);

        // Basic write then read
        xact(0, 32'h08, 32'hA5A5_1234, 4'hF);
        xact(0, 32'h08, 32'h0, 4'h0);
        check("basic_read", rdata[0], 32'hA5A5_1234);

        // Byte-lane merge
        xact(0, 32'h00, 32'h0000_0000, 4'hF);
        xact(0, 32'h00, 32'hFFFF_FFFF, 4'b0010);
        xact(0, 32'h03, 32'h0, 4'h0);
        check("lane_read", rdata[0], 32'h0000_FF00);

        // Out of range and last in-range word
        xact(0, 32'h80, 32'h0, 4'h0);
        check("oob_rdata", rdata[0], 32'hDEAD_BEEF);
        xact(0, 32'h100, 32'h1234_5678, 4'hF);
        check("oob_first_addr", oaddr[0], 32'h80);
        xact(0, 32'h7C, 32'h0, 4'h0);
        xact(0, 32'h7D, 32'h0BAD_F00D, 4'b1001);
        xact(0, 32'h7C, 32'h0, 4'h0);

        // Random traffic, in and out of range
        for (int i = 0; i < 300; i++) begin
            a  = 32'($urandom_range(0, 32'hA3));
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            xact(0, a, $urandom, ws);
        end

        // Saturation: preload the read counter near its ceiling.
        force dut0.rd_cnt_q = 16'hFFFD;
        step();
        release dut0.rd_cnt_q;
        exp_rd[0] = 16'hFFFD;
        step();
        check("sat_preload", 32'(rdc[0]), 32'h0000_FFFD);
        for (int i = 0; i < 4; i++) xact(0, 32'h08, 32'h0, 4'h0);
        check("sat_hold", 32'(rdc[0]), 32'h0000_FFFF);

        // Second instance: offset base, longer waits
        for (int i = 0; i < 16; i++)
            xact(1, 32'h1000 + 32'(i * 4), $urandom, 4'hF);
        xact(1, 32'h1008, 32'hA5A5_1234, 4'hF);
        xact(1, 32'h1008, 32'h0, 4'h0);
        xact(1, 32'h0FFC, 32'h0, 4'h0);
        check("oob_below_base", oaddr[1], 32'h0FFC);
        xact(1, 32'h1040, 32'hFFFF_FFFF, 4'hF);
        xact(1, 32'h103C, 32'h0, 4'h0);

        // Abort: request withdrawn while waiting
        valid[1] = 1'b1; addr[1] = 32'h1008; wstrb[1] = 4'h0;
        step();
        check("abort_t1", 32'(ready[1]), 0);
        step();
        check("abort_t2", 32'(ready[1]), 0);
        valid[1] = 1'b0;
        step();
        check("abort_t3", 32'(ready[1]), 0);
        check_stats(1, "abort");
        step();
        xact(1, 32'h1008, 32'h0, 4'h0);

        // Reset while waiting
        valid[1] = 1'b1; addr[1] = 32'h1008; wstrb[1] = 4'h0;
        step();
        step();
        rst[1]   = 1'b1;
        valid[1] = 1'b0;
        step();
        rst[1] = 1'b0;
        clr_model(1);
        check("rst_ready", 32'(ready[1]), 0);
        check("rst_rdata", rdata[1], 0);
        check_stats(1, "rst");
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_pulse", 32'(ready[1]), 0);
        end
        xact(1, 32'h1008, 32'h0, 4'h0);
        check("ram_kept", rdata[1], 32'hA5A5_1234);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/native_mem_responder.md
Name: native_mem_responder

Overview:
- Responder (memory) side of the picorv32 native memory interface: accepts `mem_valid` requests and answers with a `mem_ready` handshake after a configurable number of wait states.
- Holds a word-organised RAM with byte-lane writes.
- Flags out-of-range accesses, and keeps read and write statistics.
- Sits directly on the CPU's `mem_*` bus in the top-level wrapper, replacing the hard-wired ready.

Parameters:
- WORDS, 32: RAM depth in 32-bit words; any value ≥ 2; index width = $clog2(WORDS).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- READ_WAIT, 1: wait cycles inserted before a read response (0..15).
- WRITE_WAIT, 0: wait cycles inserted before a write response (0..15).
- OOB_RDATA, 32'hDEAD_BEEF: data returned for out-of-range reads.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_valid  input  1  request valid from initiator.
- mem_instr  input  1  instruction-fetch qualifier; accepted but unused.
- mem_ready  output  1  one-cycle response pulse.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte-lane write enables; 4'b0000 means read.
- mem_rdata  output  32  read data, valid while mem_ready=1 for reads.
- oob_err  output  1  sticky out-of-range flag.
- oob_addr  output  32  address of the first out-of-range access.
- rd_count  output  16  completed reads, saturating.
- wr_count  output  16  completed writes, saturating.

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, oob_err=0, oob_addr=0, rd_count=0, wr_count=0, FSM=IDLE, wait counter=0. RAM contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, with mem_valid=1 in cycle T:
  - Latch addr, wdata, wstrb. is_write = |wstrb.
  - N = is_write ? WRITE_WAIT : READ_WAIT.
  - Go to WAIT with counter=N if N>0, else go to RESP.
- WAIT:
  - Counter decrements each cycle; at counter==1 go to RESP.
  - If mem_valid is sampled 0 in WAIT (abort), go to IDLE: no write, no ready, no counter update.
- RESP:
  - mem_ready=1 for exactly this cycle (registered output); next state is IDLE.
  - mem_ready rises in cycle T+1+N.
- Reads:
  - Index = (latched_addr - BASE_ADDR) >> 2.
  - mem_rdata is registered on entry to RESP with RAM[index], or OOB_RDATA if out of range.
  - mem_rdata holds its value until the next read response; writes never change it.
- Writes:
  - At the posedge ending RESP, update RAM[index] byte lanes: lane k takes wdata[8k+7:8k] when wstrb[k]=1.
  - Lanes with wstrb[k]=0 are untouched.
- Out of range: addr < BASE_ADDR, or index ≥ WORDS.
  - Still responds with normal latency so the CPU never hangs.
  - Writes are dropped.
  - oob_err is set at RESP and stays set until reset.
  - oob_addr captures the full 32-bit latched address only when oob_err was 0; later OOB accesses do not overwrite it.
- Counters:
  - rd_count / wr_count increment in the RESP cycle of a completed read / write, OOB accesses included.
  - Both saturate at 16'hFFFF.
- mem_valid is ignored while in WAIT (except for abort detection) and in RESP; latched fields do not change mid-transaction.
- The cycle after RESP is IDLE and may accept a new request immediately.
- Reset asserted in any state, including mid-WAIT:
  - Next cycle is IDLE with mem_ready=0.
  - The pending transaction is discarded with no write.
  - Outputs return to their reset values.

Test Plan:
- Defaults (WORDS=32, READ_WAIT=1, WRITE_WAIT=0). Write addr 0x08, wdata 0xA5A5_1234, wstrb 4'hF at T → mem_ready pulse at T+1 only; wr_count=1. Then read 0x08 at T' → mem_ready at T'+2 with mem_rdata=0xA5A5_1234; rd_count=1.
- Byte lanes: write 0x0000_0000 to addr 0x0 with wstrb 4'hF, then write 0xFFFF_FFFF with wstrb 4'b0010 → read 0x0 returns 0x0000_FF00.
- OOB: read addr 0x80 → ready at T+2, mem_rdata=0xDEAD_BEEF, oob_err=1, oob_addr=0x80. Then write 0x100 → ready at T+1, oob_addr stays 0x80, RAM unchanged.
- Abort: READ_WAIT=3, read issued at T, mem_valid dropped at T+2 → no mem_ready pulse, rd_count unchanged; a new read at T+4 completes at T+8.
- Reset mid-WAIT: READ_WAIT=3, assert reset at T+2 → mem_ready stays 0; counters and oob flags cleared. Prior RAM data at 0x08 is still read back as 0xA5A5_1234 after reset.
- Saturation: force 65,537 reads → rd_count=0xFFFF and holds.
